iter_counter: RTL and testbench

Parametrised iteration counter that sequences multi-cycle arithmetic units such as the Booth multiplier and the divider. It generalises the fixed 4-bit, free-running step counter in four ways:
- width is a parameter;
- the iteration limit is loaded at run time;
- the run starts on command, can be stalled and can be aborted;
- completion is reported through a registered one-cycle `done` pulse and a combinational `last` flag.

It sits between the multdiv control FSM and its datapath.

---
 rtl/iter_counter_if.sv | 14 +
 rtl/iter_counter.sv | 39 +++
 tb/tb_iter_counter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_counter_if.sv
// iter_counter_if: control/status bundle between the multdiv FSM and the iteration counter.
interface iter_counter_if #(parameter int WIDTH = 5);
    logic             start;
    logic [WIDTH-1:0] limit;
    logic             stall;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             last;
    logic             done;

    modport master (output start, limit, stall, abort, input count, busy, last, done);
    modport slave  (input start, limit, stall, abort, output count, busy, last, done);
endinterface

// File: rtl/iter_counter.sv
// iter_counter: run-time limited iteration counter with stall/abort/restart and a registered done pulse.
module iter_counter #(parameter int WIDTH = 5) (
    input logic           clk,
    input logic           reset,
    iter_counter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] limit_q;

    // Ending at limit_q rather than on overflow keeps count from ever wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count_q <= '0;
            limit_q <= '0;
        end else if (bus.abort) begin
            state <= IDLE;
        end else if (bus.start) begin
            state   <= RUN;
            count_q <= '0;
            limit_q <= bus.limit;
        end else if (state == RUN) begin
            if (!bus.stall) begin
                if (count_q == limit_q) state <= DONE;
                else count_q <= count_q + 1'b1;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = state == RUN;
    assign bus.done  = state == DONE;
    assign bus.last  = state == RUN && count_q == limit_q;
endmodule

// File: tb/tb_iter_counter.sv
// tb_iter_counter: directed scenarios for iter_counter, sampling outputs on the falling edge.
module tb_iter_counter;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   failed = 0;

    iter_counter_if #(.WIDTH(5)) bus ();
    iter_counter #(.WIDTH(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge where outputs are compared and inputs changed.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== 8'b000_00000) begin
            failed++;
            $display("FAIL reset: busy/last/done/count=%b want 00000000", {bus.busy, bus.last, bus.done, bus.count});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_run15();
        bus.limit = 5'd15;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.limit = 5'd3;
        for (int i = 0; i <= 16; i++) begin
            tests++;
            if (i < 16) begin
                if ({bus.busy, bus.last, bus.done, bus.count} !== {1'b1, i == 15, 1'b0, 5'(i)}) begin
                    failed++;
                    $display("FAIL run15 cycle %0d: busy/last/done/count=%b want %b", i + 1,
                             {bus.busy, bus.last, bus.done, bus.count}, {1'b1, i == 15, 1'b0, 5'(i)});
                end
            end else if ({bus.busy, bus.last, bus.done, bus.count} !== {3'b001, 5'd15}) begin
                failed++;
                $display("FAIL run15 done cycle: busy/last/done/count=%b want 00101111", {bus.busy, bus.last, bus.done, bus.count});
            end
            step();
        end
        tests++;
        if ({bus.busy, bus.done, bus.count} !== {2'b00, 5'd15}) begin
            failed++;
            $display("FAIL run15 idle: busy/done/count=%b want 0001111", {bus.busy, bus.done, bus.count});
        end
    endtask

    task automatic test_limit_zero();
        bus.limit = 5'd0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== 8'b110_00000) begin
            failed++;
            $display("FAIL limit0 cycle1: busy/last/done/count=%b want 11000000", {bus.busy, bus.last, bus.done, bus.count});
        end
        step();
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== 8'b001_00000) begin
            failed++;
            $display("FAIL limit0 cycle2: busy/last/done/count=%b want 00100000", {bus.busy, bus.last, bus.done, bus.count});
        end
        step();
        tests++;
        if (bus.done !== 1'b0) begin
            failed++;
            $display("FAIL limit0 pulse: done=%b want 0", bus.done);
        end
    endtask

    // Two stalls at count 3 and one at count 31: done lands at cycle 31+2+3 = 36.
    task automatic test_stall();
        logic [4:0] exp = 5'd0;
        int s3 = 2;
        int s31 = 1;
        bus.limit = 5'd31;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            tests++;
            if (cyc == 36) begin
                if ({bus.busy, bus.last, bus.done, bus.count} !== 8'b001_11111) begin
                    failed++;
                    $display("FAIL stall done cycle 36: busy/last/done/count=%b want 00111111", {bus.busy, bus.last, bus.done, bus.count});
                end
            end else if ({bus.busy, bus.last, bus.done, bus.count} !== {1'b1, exp == 5'd31, 1'b0, exp}) begin
                failed++;
                $display("FAIL stall cycle %0d: busy/last/done/count=%b want %b", cyc,
                         {bus.busy, bus.last, bus.done, bus.count}, {1'b1, exp == 5'd31, 1'b0, exp});
            end
            bus.stall = 1'b0;
            if (exp == 5'd3 && s3 > 0) begin bus.stall = 1'b1; s3--; end
            if (exp == 5'd31 && s31 > 0) begin bus.stall = 1'b1; s31--; end
            if (!bus.stall && exp != 5'd31) exp++;
            step();
        end
        bus.stall = 1'b0;
    endtask

    task automatic test_abort();
        bus.limit = 5'd20;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        tests++;
        if (bus.count !== 5'd7) begin
            failed++;
            $display("FAIL abort pre: count=%0d want 7", bus.count);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== {3'b000, 5'd7}) begin
            failed++;
            $display("FAIL abort: busy/last/done/count=%b want 00000111", {bus.busy, bus.last, bus.done, bus.count});
        end
        step();
        tests++;
        if ({bus.busy, bus.done, bus.count} !== {2'b00, 5'd7}) begin
            failed++;
            $display("FAIL abort idle: busy/done/count=%b want 0000111", {bus.busy, bus.done, bus.count});
        end
        bus.limit = 5'd2;
        bus.start = 1'b1;
        step();
        tests++;
        if ({bus.busy, bus.done, bus.count} !== 7'b10_00000) begin
            failed++;
            $display("FAIL abort restart: busy/done/count=%b want 1000000", {bus.busy, bus.done, bus.count});
        end
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tests++;
        if ({bus.busy, bus.done, bus.count} !== {2'b00, 5'd1}) begin
            failed++;
            $display("FAIL abort+start: busy/done/count=%b want 0000001", {bus.busy, bus.done, bus.count});
        end
    endtask

    task automatic test_back_to_back();
        bus.limit = 5'd20;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        tests++;
        if (bus.count !== 5'd9) begin
            failed++;
            $display("FAIL restart pre: count=%0d want 9", bus.count);
        end
        bus.limit = 5'd4;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            tests++;
            if ({bus.busy, bus.last, bus.done, bus.count} !== {1'b1, i == 4, 1'b0, 5'(i)}) begin
                failed++;
                $display("FAIL restart run cycle %0d: busy/last/done/count=%b want %b", i + 1,
                         {bus.busy, bus.last, bus.done, bus.count}, {1'b1, i == 4, 1'b0, 5'(i)});
            end
            step();
        end
        tests++;
        if ({bus.busy, bus.done, bus.count} !== {2'b01, 5'd4}) begin
            failed++;
            $display("FAIL restart done: busy/done/count=%b want 0100100", {bus.busy, bus.done, bus.count});
        end
        bus.limit = 5'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== 8'b100_00000) begin
            failed++;
            $display("FAIL b2b first: busy/last/done/count=%b want 10000000", {bus.busy, bus.last, bus.done, bus.count});
        end
        step();
        step();
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== {3'b110, 5'd2}) begin
            failed++;
            $display("FAIL b2b last: busy/last/done/count=%b want 11000010", {bus.busy, bus.last, bus.done, bus.count});
        end
        step();
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== {3'b001, 5'd2}) begin
            failed++;
            $display("FAIL b2b done: busy/last/done/count=%b want 00100010", {bus.busy, bus.last, bus.done, bus.count});
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.limit = 5'd20;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (12) step();
        tests++;
        if (bus.count !== 5'd12) begin
            failed++;
            $display("FAIL reset-mid pre: count=%0d want 12", bus.count);
        end
        reset = 1'b1;
        step();
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== 8'b000_00000) begin
            failed++;
            $display("FAIL reset-mid: busy/last/done/count=%b want 00000000", {bus.busy, bus.last, bus.done, bus.count});
        end
        bus.limit = 5'd5;
        bus.start = 1'b1;
        step();
        tests++;
        if ({bus.busy, bus.last, bus.done, bus.count} !== 8'b000_00000) begin
            failed++;
            $display("FAIL reset+start: busy/last/done/count=%b want 00000000", {bus.busy, bus.last, bus.done, bus.count});
        end
        bus.start = 1'b0;
        reset = 1'b0;
        step();
        tests++;
        if (bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL reset+start after: busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.limit = '0;
        bus.stall = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_run15();
        test_limit_zero();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
